// File: rtl/rst_req_ctrl_pkg.sv
// Shared definitions for the reset-request controller: FSM state encoding
// and the bit positions of the sticky reset-cause register.
package rst_req_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2
   } rst_state_e;

   localparam int CAUSE_W   = 3;
   localparam int CAUSE_BTN = 0;
   localparam int CAUSE_SW  = 1;
   localparam int CAUSE_WDT = 2;

endpackage

// File: rtl/rst_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer followed by a stability
// counter. btn_ok only follows the synchronized level once it has held
// still for DEBOUNCE_CYCLES consecutive cycles.
module rst_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_l,
   input  logic btn_raw,
   output logic btn_ok
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          sync_prev;
   logic [CW-1:0] stable_cnt;

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   // Restart the count on any change; accept the level once it stayed put.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sync_prev  <= 1'b0;
         stable_cnt <= '0;
         btn_ok     <= 1'b0;
      end else begin
         sync_prev <= sync_q2;
         if (sync_q2 != sync_prev)
            stable_cnt <= '0;
         else if (stable_cnt == CNT_LAST)
            btn_ok <= sync_q2;
         else
            stable_cnt <= stable_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rst_req_ctrl.sv
// Reset-request controller: merges button, software and watchdog reset
// sources into one stretched, registered reset request and records which
// sources fired in a sticky cause register.
module rst_req_ctrl
   import rst_req_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STRETCH_CYCLES  = 64,
   parameter int WDT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 btn_rst_in,
   input  logic                 sw_rst_req,
   input  logic                 wdt_en,
   input  logic                 wdt_kick,
   input  logic [WDT_WIDTH-1:0] wdt_load,
   input  logic                 cause_clr,
   output logic                 rst_req,
   output logic                 rst_busy,
   output logic [CAUSE_W-1:0]   rst_cause,
   output logic [WDT_WIDTH-1:0] wdt_count
);

   localparam int            SW           = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
   localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES - 1);

   rst_state_e           state;
   rst_state_e           state_nxt;
   logic [SW-1:0]        stretch_cnt;
   logic                 btn_ok;
   logic                 btn_ok_d;
   logic                 wdt_en_d;
   logic                 wdt_reload;
   logic                 wdt_zero;
   logic                 assert_done;
   logic [CAUSE_W-1:0]   evt_vec;

   rst_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk     (clk),
      .rst_l   (rst_l),
      .btn_raw (btn_rst_in),
      .btn_ok  (btn_ok)
   );

   // An enable rising edge counts as a load, so the first cycle after reset
   // with wdt_en already high loads the counter instead of firing.
   assign wdt_reload  = wdt_en & (~wdt_en_d | wdt_kick);
   assign wdt_zero    = (wdt_count == '0);
   assign assert_done = (state == ST_ASSERT) && (stretch_cnt == '0);

   // Per-source events of this cycle, one bit per cause.
   always_comb begin
      evt_vec            = '0;
      evt_vec[CAUSE_BTN] = btn_ok & ~btn_ok_d;
      evt_vec[CAUSE_SW]  = sw_rst_req;
      evt_vec[CAUSE_WDT] = wdt_en & wdt_zero & ~wdt_reload;
   end

   // Next state. The stretch leaves ASSERT straight to IDLE when the button
   // is already released, so the request is exactly STRETCH_CYCLES wide;
   // HOLD only covers a button still being held.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (|evt_vec)         state_nxt = ST_ASSERT;
         ST_ASSERT: if (stretch_cnt == '0) state_nxt = btn_ok ? ST_HOLD : ST_IDLE;
         ST_HOLD:   if (!btn_ok)          state_nxt = ST_IDLE;
         default:                         state_nxt = ST_IDLE;
      endcase
   end

   // FSM, stretch counter and registered request/busy outputs.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state       <= ST_IDLE;
         stretch_cnt <= '0;
         rst_req     <= 1'b0;
         rst_busy    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && state_nxt == ST_ASSERT)
            stretch_cnt <= STRETCH_LOAD;
         else if (state == ST_ASSERT && stretch_cnt != '0)
            stretch_cnt <= stretch_cnt - 1'b1;
         rst_req  <= (state_nxt != ST_IDLE);
         rst_busy <= (state_nxt != ST_IDLE);
      end
   end

   // Sticky causes; a coincident event wins over a clear.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)
         rst_cause <= '0;
      else
         rst_cause <= (cause_clr ? '0 : rst_cause) | evt_vec;
   end

   // Edge-detect history for the button and watchdog enable.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         btn_ok_d <= 1'b0;
         wdt_en_d <= 1'b0;
      end else begin
         btn_ok_d <= btn_ok;
         wdt_en_d <= wdt_en;
      end
   end

   // Watchdog counter: load on enable edge, kick or end of the stretch
   // (the point where the request moves past ASSERT), else count down.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)
         wdt_count <= '0;
      else if (wdt_reload || assert_done)
         wdt_count <= wdt_load;
      else if (wdt_en && !wdt_zero)
         wdt_count <= wdt_count - 1'b1;
   end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Scenario bench for rst_req_ctrl: expected reset pulses are queued when a
// scenario drives its stimulus and matched against pulses seen on rst_req.
module tb_rst_req_ctrl;

   localparam int WW = 32;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic          btn_rst_in = 1'b0;
   logic          sw_rst_req = 1'b0;
   logic          wdt_en = 1'b0;
   logic          wdt_kick = 1'b0;
   logic [WW-1:0] wdt_load = '0;
   logic          cause_clr = 1'b0;
   logic          rst_req;
   logic          rst_busy;
   logic [2:0]    rst_cause;
   logic [WW-1:0] wdt_count;

   rst_req_ctrl #(
      .DEBOUNCE_CYCLES (16),
      .STRETCH_CYCLES  (64),
      .WDT_WIDTH       (WW)
   ) dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .btn_rst_in (btn_rst_in),
      .sw_rst_req (sw_rst_req),
      .wdt_en     (wdt_en),
      .wdt_kick   (wdt_kick),
      .wdt_load   (wdt_load),
      .cause_clr  (cause_clr),
      .rst_req    (rst_req),
      .rst_busy   (rst_busy),
      .rst_cause  (rst_cause),
      .wdt_count  (wdt_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int start;
      int stop;
   } pulse_t;

   pulse_t exp_q[$];
   pulse_t obs_q[$];
   logic   in_pulse = 1'b0;
   int     p_start = 0;
   int     n_pass = 0;
   int     n_total = 0;

   // Record each rst_req pulse as (first high cycle, first low cycle).
   always @(negedge clk) begin
      if (rst_req === 1'b1 && !in_pulse) begin
         in_pulse <= 1'b1;
         p_start  <= cyc;
      end else if (rst_req !== 1'b1 && in_pulse) begin
         in_pulse <= 1'b0;
         obs_q.push_back('{p_start, cyc});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic goto(input int n);
      if (n > cyc) step(n - cyc);
   endtask

   task automatic wait_obs(input int n);
      int g;
      g = 0;
      while (obs_q.size() < n && g < 400) begin
         step(1);
         g++;
      end
   endtask

   task automatic pop_pulse(output pulse_t e, output pulse_t o);
      e = exp_q.pop_front();
      o.start = -1;
      o.stop  = -1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
   endtask

   task automatic clear_cause;
      cause_clr = 1'b1;
      step(1);
      cause_clr = 1'b0;
      step(1);
   endtask

   task automatic test_reset;
      step(2);
      n_total++;
      if ({rst_req, rst_busy, rst_cause} !== 5'b0 || wdt_count !== '0)
         $display("FAIL reset_state: req=%b busy=%b cause=%b cnt=%0d, want all 0", rst_req, rst_busy, rst_cause, wdt_count);
      else n_pass++;
      rst_l = 1'b1;
      step(3);
      @(negedge clk);
      n_total++;
      if (rst_req !== 1'b0 || rst_busy !== 1'b0)
         $display("FAIL reset_release: req=%b busy=%b, want 0 0", rst_req, rst_busy);
      else n_pass++;
   endtask

   task automatic test_sw_request;
      pulse_t e, o;
      int s;
      s = cyc + 2;
      goto(s);
      sw_rst_req = 1'b1;
      exp_q.push_back('{s + 1, s + 65});
      step(1);
      sw_rst_req = 1'b0;
      @(negedge clk);
      n_total++;
      if (rst_busy !== 1'b1) $display("FAIL sw_busy: busy=%b want 1", rst_busy);
      else n_pass++;
      wait_obs(1);
      pop_pulse(e, o);
      n_total++;
      if (o.start != e.start || o.stop != e.stop)
         $display("FAIL sw_pulse: cycles %0d..%0d, want %0d..%0d", o.start, o.stop, e.start, e.stop);
      else n_pass++;
      n_total++;
      if (rst_cause !== 3'b010) $display("FAIL sw_cause: %b want 010", rst_cause);
      else n_pass++;
      clear_cause();
      n_total++;
      if (rst_cause !== 3'b000) $display("FAIL sw_cause_clr: %b want 000", rst_cause);
      else n_pass++;
   endtask

   task automatic test_btn_bounce;
      pulse_t o;
      int t, r;
      for (int k = 0; k < 8; k++) begin
         btn_rst_in = (k % 2 == 0);
         step(5);
      end
      btn_rst_in = 1'b1;
      t = cyc;
      goto(t + 120);
      btn_rst_in = 1'b0;
      r = cyc;
      wait_obs(1);
      o.start = -1;
      o.stop  = -1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_total++;
      if (o.start < t + 18 || o.start > t + 22)
         $display("FAIL btn_start: rose at %0d, want %0d..%0d", o.start, t + 18, t + 22);
      else n_pass++;
      n_total++;
      if (o.stop < r + 18 || o.stop > r + 22)
         $display("FAIL btn_release: fell at %0d, want %0d..%0d", o.stop, r + 18, r + 22);
      else n_pass++;
      n_total++;
      if (rst_cause !== 3'b001) $display("FAIL btn_cause: %b want 001", rst_cause);
      else n_pass++;
      clear_cause();
   endtask

   task automatic test_wdt_expiry;
      pulse_t e, o;
      int c;
      wdt_load = 100;
      c = cyc + 1;
      goto(c);
      wdt_en = 1'b1;
      exp_q.push_back('{c + 102, c + 166});
      goto(c + 1);
      @(negedge clk);
      n_total++;
      if (wdt_count !== 100) $display("FAIL wdt_load: count=%0d want 100", wdt_count);
      else n_pass++;
      goto(c + 51);
      @(negedge clk);
      n_total++;
      if (wdt_count !== 50) $display("FAIL wdt_decrement: count=%0d want 50", wdt_count);
      else n_pass++;
      wait_obs(1);
      wdt_en = 1'b0;
      pop_pulse(e, o);
      n_total++;
      if (o.start != e.start || o.stop != e.stop)
         $display("FAIL wdt_pulse: cycles %0d..%0d, want %0d..%0d", o.start, o.stop, e.start, e.stop);
      else n_pass++;
      n_total++;
      if (rst_cause !== 3'b100) $display("FAIL wdt_cause: %b want 100", rst_cause);
      else n_pass++;
      clear_cause();
   endtask

   task automatic test_wdt_zero_load;
      pulse_t e, o;
      int c;
      wdt_load = 0;
      c = cyc + 1;
      goto(c);
      wdt_en = 1'b1;
      exp_q.push_back('{c + 2, c + 66});
      goto(c + 3);
      wdt_en = 1'b0;
      wait_obs(1);
      pop_pulse(e, o);
      n_total++;
      if (o.start != e.start || o.stop != e.stop)
         $display("FAIL wdt_zero_pulse: cycles %0d..%0d, want %0d..%0d", o.start, o.stop, e.start, e.stop);
      else n_pass++;
      clear_cause();
   endtask

   task automatic test_kick_at_zero;
      int c;
      wdt_load = 5;
      c = cyc + 1;
      goto(c);
      wdt_en = 1'b1;
      goto(c + 6);
      wdt_kick = 1'b1;
      @(negedge clk);
      n_total++;
      if (wdt_count !== 0) $display("FAIL kick_zero_count: count=%0d want 0", wdt_count);
      else n_pass++;
      step(1);
      wdt_kick = 1'b0;
      @(negedge clk);
      n_total++;
      if (wdt_count !== 5) $display("FAIL kick_reload: count=%0d want 5", wdt_count);
      else n_pass++;
      goto(c + 8);
      wdt_en = 1'b0;
      goto(c + 12);
      @(negedge clk);
      n_total++;
      if (wdt_count !== 4) $display("FAIL wdt_freeze: count=%0d want 4", wdt_count);
      else n_pass++;
      n_total++;
      if (obs_q.size() != 0 || in_pulse || rst_cause !== 3'b000)
         $display("FAIL kick_no_event: pulses=%0d active=%b cause=%b, want 0 0 000", obs_q.size(), in_pulse, rst_cause);
      else n_pass++;
   endtask

   task automatic test_overlap;
      pulse_t e, o;
      int s, x;
      s = cyc + 10;
      goto(s - 5);
      wdt_load = 24;
      wdt_en = 1'b1;
      goto(s);
      sw_rst_req = 1'b1;
      exp_q.push_back('{s + 1, s + 65});
      step(1);
      sw_rst_req = 1'b0;
      goto(s + 20);
      @(negedge clk);
      n_total++;
      if (wdt_count !== 0) $display("FAIL overlap_wdt_zero: count=%0d want 0", wdt_count);
      else n_pass++;
      goto(s + 40);
      wdt_en = 1'b0;
      wait_obs(1);
      pop_pulse(e, o);
      n_total++;
      if (o.start != e.start || o.stop != e.stop)
         $display("FAIL overlap_pulse: cycles %0d..%0d, want %0d..%0d", o.start, o.stop, e.start, e.stop);
      else n_pass++;
      n_total++;
      if (rst_cause !== 3'b110) $display("FAIL overlap_cause: %b want 110", rst_cause);
      else n_pass++;
      // Clear and a new software event in the same cycle: the event survives.
      x = cyc + 2;
      goto(x);
      cause_clr = 1'b1;
      sw_rst_req = 1'b1;
      exp_q.push_back('{x + 1, x + 65});
      step(1);
      cause_clr = 1'b0;
      sw_rst_req = 1'b0;
      @(negedge clk);
      n_total++;
      if (rst_cause !== 3'b010) $display("FAIL clr_vs_event: %b want 010", rst_cause);
      else n_pass++;
      wait_obs(1);
      pop_pulse(e, o);
      n_total++;
      if (o.start != e.start || o.stop != e.stop)
         $display("FAIL clr_event_pulse: cycles %0d..%0d, want %0d..%0d", o.start, o.stop, e.start, e.stop);
      else n_pass++;
      clear_cause();
      n_total++;
      if (rst_cause !== 3'b000) $display("FAIL overlap_clr: %b want 000", rst_cause);
      else n_pass++;
   endtask

   task automatic test_reset_mid_pulse;
      pulse_t e, o;
      int s;
      s = cyc + 2;
      goto(s);
      sw_rst_req = 1'b1;
      exp_q.push_back('{s + 1, s + 21});
      step(1);
      sw_rst_req = 1'b0;
      goto(s + 21);
      rst_l = 1'b0;
      #1;
      n_total++;
      if (rst_req !== 1'b0 || rst_busy !== 1'b0)
         $display("FAIL async_drop: req=%b busy=%b want 0 0", rst_req, rst_busy);
      else n_pass++;
      step(2);
      rst_l = 1'b1;
      step(1);
      @(negedge clk);
      n_total++;
      if ({rst_req, rst_busy, rst_cause} !== 5'b0 || wdt_count !== '0)
         $display("FAIL post_reset: req=%b busy=%b cause=%b cnt=%0d, want all 0", rst_req, rst_busy, rst_cause, wdt_count);
      else n_pass++;
      wait_obs(1);
      pop_pulse(e, o);
      n_total++;
      if (o.start != e.start || o.stop != e.stop)
         $display("FAIL cut_pulse: cycles %0d..%0d, want %0d..%0d", o.start, o.stop, e.start, e.stop);
      else n_pass++;
      step(20);
      n_total++;
      if (obs_q.size() != 0 || in_pulse || rst_busy !== 1'b0)
         $display("FAIL no_pending: pulses=%0d active=%b busy=%b, want 0 0 0", obs_q.size(), in_pulse, rst_busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_sw_request();
      test_btn_bounce();
      test_wdt_expiry();
      test_wdt_zero_load();
      test_kick_at_zero();
      test_overlap();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench still running at cycle %0d, want finished", cyc);
      $fatal(1);
   end

endmodule
